// File: rtl/med_sched_pkg.sv
// Shared types and widths for the median filter frame scheduler.
package med_sched_pkg;

    localparam int CNT_W = 11;
    localparam int PIX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage

// File: rtl/med_sched_timing.sv
// Horizontal/vertical position counters for one generated frame, with the
// strobes the scheduler FSM steps on (active-line end, line end, lead-in end, frame end).
module med_sched_timing
    import med_sched_pkg::*;
#(
    parameter int IMG_HDISP = 400,
    parameter int IMG_VDISP = 300,
    parameter int H_BLANK   = 16,
    parameter int V_BLANK   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hact_end,
    output logic line_end,
    output logic lead_end,
    output logic frame_end
);

    localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(IMG_HDISP - 1);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(IMG_HDISP + H_BLANK - 1);
    localparam logic [CNT_W-1:0] V_LEAD_LAST = CNT_W'(V_BLANK - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_BLANK + IMG_VDISP - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    // v_cnt spans lead-in lines and active lines alike; line 0 of the image is v_cnt == V_BLANK.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign hact_end  = (h_cnt == H_ACT_LAST);
    assign line_end  = (h_cnt == H_LAST);
    assign lead_end  = line_end && (v_cnt == V_LEAD_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);

endmodule

// File: rtl/median_frame_scheduler.sv
// Frame controller in front of the median filter: synthesises vsync/href timing, tracks the
// filter's delayed output to frame completion. Bypass routing is built only with MED_SCHED_BYPASS_EN.
module median_frame_scheduler
    import med_sched_pkg::*;
#(
    parameter int IMG_HDISP = 400,
    parameter int IMG_VDISP = 300,
    parameter int H_BLANK   = 16,
    parameter int V_BLANK   = 4,
    parameter int DRAIN_MAX = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bypass_req,
    input  logic             src_valid,
    input  logic [PIX_W-1:0] src_gray,
    output logic             src_ready,
    output logic             per_img_vsync,
    output logic             per_img_href,
    output logic [PIX_W-1:0] per_img_gray,
    input  logic             post_img_vsync,
    input  logic             post_img_href,
    input  logic [PIX_W-1:0] post_img_gray,
    output logic             out_img_vsync,
    output logic             out_img_href,
    output logic [PIX_W-1:0] out_img_gray,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun,
    output logic             timeout,
    output logic [2:0]       dbg_state
);

    localparam int WD_W = $clog2(DRAIN_MAX + 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] FALL_ALL  = CNT_W'(IMG_VDISP);
    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(IMG_VDISP - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             running;
    logic             hact_end;
    logic             line_end;
    logic             lead_end;
    logic             frame_end;
    logic             gen_vsync;
    logic             gen_href;
    logic [PIX_W-1:0] gen_gray;
    logic             bypass_q;
    logic             post_href_d;
    logic             fall_now;
    logic             fall_complete;
    logic [CNT_W-1:0] fall_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             drain_done;
    logic             wd_expire;

    assign accept    = (state == ST_IDLE) && start;
    assign running   = (state == ST_LEAD) || (state == ST_ACTIVE) || (state == ST_HBLANK);
    assign dbg_state = state;

    // Source handshake: a pixel slot is consumed on every cycle src_ready is high, whatever
    // src_valid says. Geometry never stalls; a slot with src_valid low is a starve and becomes 0.
    assign src_ready = (state == ST_ACTIVE);

    med_sched_timing #(
        .IMG_HDISP (IMG_HDISP),
        .IMG_VDISP (IMG_VDISP),
        .H_BLANK   (H_BLANK),
        .V_BLANK   (V_BLANK)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .en        (running),
        .hact_end  (hact_end),
        .line_end  (line_end),
        .lead_end  (lead_end),
        .frame_end (frame_end)
    );

    // Filter latency can exceed a line, so falling edges are counted from LEAD onward, not only in DRAIN.
    assign fall_now      = post_href_d & ~post_img_href;
    assign fall_complete = (fall_cnt == FALL_ALL) || (fall_now && (fall_cnt == FALL_LAST));

    always_comb begin
        state_nxt  = state;
        drain_done = 1'b0;
        wd_expire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LEAD;
            end
            ST_LEAD: begin
                if (lead_end) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (hact_end) state_nxt = ST_HBLANK;
            end
            ST_HBLANK: begin
                if (line_end) state_nxt = frame_end ? ST_DRAIN : ST_ACTIVE;
            end
            ST_DRAIN: begin
                if (bypass_q || fall_complete) begin
                    drain_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            post_href_d <= 1'b0;
            fall_cnt    <= '0;
            wd_cnt      <= '0;
        end else begin
            post_href_d <= post_img_href;
            if (accept)
                fall_cnt <= '0;
            else if ((state != ST_IDLE) && fall_now && (fall_cnt != FALL_ALL))
                fall_cnt <= fall_cnt + 1'b1;
            wd_cnt <= (state == ST_DRAIN) ? wd_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            frame_done <= drain_done | wd_expire;
            if (accept) begin
                busy     <= 1'b1;
                underrun <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                if (drain_done || wd_expire)
                    busy <= 1'b0;
                if ((state == ST_ACTIVE) && !src_valid)
                    underrun <= 1'b1;
                if (wd_expire)
                    timeout <= 1'b1;
            end
        end
    end

    // Generated stream lags the state by one cycle, so vsync/href line up with the registered pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_vsync <= 1'b0;
            gen_href  <= 1'b0;
            gen_gray  <= '0;
        end else begin
            gen_vsync <= running;
            gen_href  <= (state == ST_ACTIVE);
            gen_gray  <= ((state == ST_ACTIVE) && src_valid) ? src_gray : '0;
        end
    end

`ifdef MED_SCHED_BYPASS_EN
    always_ff @(posedge clk) begin
        if (rst)         bypass_q <= 1'b0;
        else if (accept) bypass_q <= bypass_req;
    end

    assign out_img_vsync = bypass_q ? gen_vsync : post_img_vsync;
    assign out_img_href  = bypass_q ? gen_href  : post_img_href;
    assign out_img_gray  = bypass_q ? gen_gray  : post_img_gray;
`else
    logic unused_bypass_req;
    assign unused_bypass_req = bypass_req;
    assign bypass_q          = 1'b0;

    assign out_img_vsync = post_img_vsync;
    assign out_img_href  = post_img_href;
    assign out_img_gray  = post_img_gray;
`endif

    assign per_img_vsync = gen_vsync & ~bypass_q;
    assign per_img_href  = gen_href & ~bypass_q;
    assign per_img_gray  = bypass_q ? '0 : gen_gray;

endmodule
